mux_arb_n: RTL and testbench
============================

# mux_arb_n

Registered, parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the combinational 2:1 four-bit multiplexer. The select is either driven externally (fixed mode) or generated internally by a round-robin arbiter. One output register stage provides a 1-cycle latency at full throughput. It sits between several producer channels and a single consumer in the datapath labs.

## Interface
- WIDTH, 4: data bits per channel (1..32).
- NCH, 4: number of input channels (2..16).
- SELW, $clog2(NCH): width of channel indices (derived, not overridden).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  channel i offers a word.
- in_ready  out  NCH  channel i word accepted this cycle (one-hot or zero).
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_data  out  WIDTH  registered selected word.
- out_ch  out  SELW  index of the channel that produced out_data.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.

## Operation
- Output stage FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = EMPTY or (FULL and out_ready).
- Grant, evaluated combinationally each cycle:
  - Fixed mode: grant = sel if sel < NCH and in_valid[sel]; otherwise no grant. Other channels are never granted.
  - Round-robin mode: grant = first i with in_valid[i], searching ptr+1, ptr+2, … modulo NCH; otherwise no grant.
- Transfer on a channel: load_en and a grant exist. Then:
  - in_ready[grant]=1, all other in_ready bits 0;
  - out_data, out_ch ← granted word and index;
  - FSM → FULL;
  - in round-robin mode, ptr ← grant.
- load_en with no grant: FULL → EMPTY if out_ready; EMPTY stays EMPTY.
- FULL and not out_ready: out_data, out_ch and out_valid hold stable; in_ready = 0.
- ptr is not updated in fixed mode. It keeps its last value when switching back to round-robin.
- A change of mode or sel takes effect on the next grant decision. It never alters a word already registered.
- in_ready depends combinationally on in_valid, mode, sel, ptr, FSM state and out_ready. There is no dependency on in_data.

## Timing
- Reset values (asynchronous assert, synchronous-edge release): out_valid=0, out_data=0, out_ch=0, ptr=NCH-1 (so channel 0 has first priority), in_ready=0.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k.
- Throughput: one word per cycle while out_ready=1 and any eligible channel is valid.
- Simultaneous pop and push in FULL (out_ready=1 plus a grant) gives a back-to-back replace. out_valid stays 1 with no bubble.
- Reset asserted mid-transfer discards the registered word immediately. No in_ready pulse is produced while reset=1.
- NCH not a power of two: in fixed mode, sel ≥ NCH never grants. In round-robin mode, the wrap is at NCH, not at 2^SELW.

## Structure
- Package mux_arb_pkg holds MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module rr_arbiter: parameter NCH, with inputs req[NCH], ptr[SELW] and outputs gnt_valid, gnt_idx[SELW]. It is purely combinational (rotate, priority-encode, un-rotate). The top module owns ptr, the output register and the FSM.

## Test plan
- Reset with WIDTH=4, NCH=4 → out_valid=0, out_data=0000, out_ch=0, in_ready=0000. Assert reset mid-stream → same values immediately, before any clock edge.
- Fixed mode, sel=2, in_valid=1111, ch2=0110, out_ready=1 → in_ready=0100, next cycle out_data=0110, out_ch=2. Then sel=1 with ch1=1100 → out_data=1100, out_ch=1.
- Round-robin mode, all valid, data ch0..3=0001/0010/0100/1000, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles with out_valid continuously 1.
- Round-robin mode, in_valid=1010 → grants alternate 1,3,1,3. Drop in_valid to 0000 with out_ready=1 → out_valid falls to 0 after one cycle.
- Backpressure: FULL with out_data=0101, out_ready=0 for 3 cycles → out_data and out_ch stable and in_ready=0000 throughout. Raising out_ready gives the next word one cycle later.
- NCH=3: fixed mode with sel=3 → in_ready=000 and out_valid stays 0. Round-robin with all valid → out_ch cycles 0,1,2,0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the registered N-channel arbitrating multiplexer.
package mux_arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping at NCH.
module rr_arbiter #(
   parameter  int unsigned NCH  = 4,
   localparam int unsigned SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);

   localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

   logic [SELW:0] idx;

   // Rotate, priority-encode and un-rotate folded into one modular scan from ptr+1.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         idx = {1'b0, ptr} + (SELW+1)'(k);
         if (idx >= NCH_W) begin
            idx = idx - NCH_W;
         end
         if (!gnt_valid && req[idx[SELW-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx[SELW-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// Registered N-channel valid/ready multiplexer with fixed or round-robin channel select.
module mux_arb_n
   import mux_arb_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   parameter  int unsigned NCH   = 4,
   localparam int unsigned SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned     NPAD    = 1 << SELW;
   localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

   out_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  ch_q, ch_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             rr_valid;
   logic [SELW-1:0]  rr_idx;
   logic [NPAD-1:0]  valid_pad;
   logic             gnt_valid;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] gnt_word;
   logic             load_en;

   rr_arbiter #(
      .NCH (NCH)
   ) u_rr_arbiter (
      .req       (in_valid),
      .ptr       (ptr_q),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   // Zero padding makes any sel >= NCH see an idle channel.
   assign valid_pad = NPAD'(in_valid);

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      gnt_word  = '0;
      if (mode == MODE_RR) begin
         gnt_valid = rr_valid;
         gnt_idx   = rr_idx;
      end else begin
         gnt_valid = valid_pad[sel];
         gnt_idx   = sel;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         if (gnt_idx == SELW'(i)) begin
            gnt_word = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign load_en = (state_q == ST_EMPTY) || out_ready;

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      ch_d     = ch_q;
      ptr_d    = ptr_q;
      in_ready = '0;
      if (load_en) begin
         if (gnt_valid) begin
            in_ready = NCH'(1) << gnt_idx;
            data_d   = gnt_word;
            ch_d     = gnt_idx;
            state_d  = ST_FULL;
            if (mode == MODE_RR) begin
               ptr_d = gnt_idx;
            end
         end else begin
            state_d = ST_EMPTY;
         end
      end
      // No acceptance may be signalled while the register is held in reset.
      if (reset) begin
         in_ready = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= PTR_RST;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: a 4-channel and a 3-channel instance driven by directed vectors.
module tb_mux_arb_n;
   import mux_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;

   logic [15:0] a_in_data;
   logic [3:0]  a_in_valid, a_in_ready;
   logic        a_mode, a_out_valid, a_out_ready;
   logic [1:0]  a_sel, a_out_ch;
   logic [3:0]  a_out_data;

   logic [11:0] b_in_data;
   logic [2:0]  b_in_valid, b_in_ready;
   logic        b_mode, b_out_valid, b_out_ready;
   logic [1:0]  b_sel, b_out_ch;
   logic [3:0]  b_out_data;

   mux_arb_n #(.WIDTH(4), .NCH(4)) dut_a (
      .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
      .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready));

   mux_arb_n #(.WIDTH(4), .NCH(3)) dut_b (
      .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
      .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready));

   typedef struct packed {
      logic [3:0] data;
      logic [1:0] ch;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   checks = 0;
   int   errors = 0;

   int rr4[5]   = '{0, 1, 2, 3, 0};
   int rr_alt[4] = '{1, 3, 1, 3};
   int rr3[4]   = '{0, 1, 2, 0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: a word is consumed at the next rising edge whenever valid and ready are both high.
   always @(negedge clk) begin
      if (a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_word: got data %0h ch %0d expected none", a_out_data, a_out_ch);
         end else begin
            ea = qa.pop_front();
            chk("a_sb_data", 32'(a_out_data), 32'(ea.data));
            chk("a_sb_ch", 32'(a_out_ch), 32'(ea.ch));
         end
      end
   end

   always @(negedge clk) begin
      if (b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_word: got data %0h ch %0d expected none", b_out_data, b_out_ch);
         end else begin
            eb = qb.pop_front();
            chk("b_sb_data", 32'(b_out_data), 32'(eb.data));
            chk("b_sb_ch", 32'(b_out_ch), 32'(eb.ch));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic a_grant(input string nm, input logic [3:0] rdy, input logic [3:0] d, input logic [1:0] ch);
      #1;
      chk({nm, "_rdy"}, 32'(a_in_ready), 32'(rdy));
      qa.push_back({d, ch});
      tick();
      chk({nm, "_valid"}, 32'(a_out_valid), 32'd1);
   endtask

   task automatic b_grant(input string nm, input logic [2:0] rdy, input logic [3:0] d, input logic [1:0] ch);
      #1;
      chk({nm, "_rdy"}, 32'(b_in_ready), 32'(rdy));
      qb.push_back({d, ch});
      tick();
      chk({nm, "_valid"}, 32'(b_out_valid), 32'd1);
   endtask

   initial begin
      reset       = 1'b1;
      a_in_data   = 16'h0;
      a_in_valid  = 4'b1111;
      a_mode      = MODE_FIXED;
      a_sel       = 2'd2;
      a_out_ready = 1'b1;
      b_in_data   = 12'h0;
      b_in_valid  = 3'b111;
      b_mode      = MODE_FIXED;
      b_sel       = 2'd0;
      b_out_ready = 1'b1;
      #3;
      chk("rst_valid", 32'(a_out_valid), 32'd0);
      chk("rst_data", 32'(a_out_data), 32'd0);
      chk("rst_ch", 32'(a_out_ch), 32'd0);
      chk("rst_rdy", 32'(a_in_ready), 32'd0);
      chk("rst_b_rdy", 32'(b_in_ready), 32'd0);
      a_in_valid = 4'b0000;
      b_in_valid = 3'b000;
      tick();
      reset = 1'b0;

      // Fixed select: channel 2, then channel 1.
      a_in_data  = {4'b1001, 4'b0110, 4'b1100, 4'b0011};
      a_in_valid = 4'b1111;
      a_grant("fix_sel2", 4'b0100, 4'b0110, 2'd2);
      chk("fix_sel2_data", 32'(a_out_data), 32'h6);
      a_sel = 2'd1;
      a_grant("fix_sel1", 4'b0010, 4'b1100, 2'd1);
      chk("fix_sel1_ch", 32'(a_out_ch), 32'd1);

      // Round robin, all channels valid: 0,1,2,3,0 back to back.
      a_in_data = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
      a_mode    = MODE_RR;
      for (int i = 0; i < 5; i++) begin
         a_grant("rr_all", 4'(1 << rr4[i]), 4'(1 << rr4[i]), 2'(rr4[i]));
      end

      // Round robin, only channels 1 and 3 valid.
      a_in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         a_grant("rr_alt", 4'(1 << rr_alt[i]), 4'(1 << rr_alt[i]), 2'(rr_alt[i]));
      end
      a_in_valid = 4'b0000;
      #1;
      chk("rr_drop_rdy", 32'(a_in_ready), 32'd0);
      tick();
      chk("rr_drop_empty", 32'(a_out_valid), 32'd0);

      // Backpressure holds the registered word and blocks all channels.
      a_mode     = MODE_FIXED;
      a_sel      = 2'd1;
      a_in_data  = {4'b1001, 4'b0110, 4'b0101, 4'b0011};
      a_in_valid = 4'b0010;
      a_grant("bp_load", 4'b0010, 4'b0101, 2'd1);
      a_out_ready     = 1'b0;
      a_in_valid      = 4'b1111;
      a_in_data[7:4]  = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_rdy", 32'(a_in_ready), 32'd0);
         chk("bp_data", 32'(a_out_data), 32'h5);
         chk("bp_ch", 32'(a_out_ch), 32'd1);
         chk("bp_valid", 32'(a_out_valid), 32'd1);
         tick();
      end
      a_out_ready = 1'b1;
      a_grant("bp_release", 4'b0010, 4'b1110, 2'd1);
      chk("bp_next_data", 32'(a_out_data), 32'hE);
      a_in_valid = 4'b0000;
      tick();
      chk("bp_drain", 32'(a_out_valid), 32'd0);

      // Reset in the middle of a held word.
      a_sel       = 2'd0;
      a_in_valid  = 4'b0001;
      a_out_ready = 1'b0;
      #1;
      chk("mid_load_rdy", 32'(a_in_ready), 32'd1);
      tick();
      chk("mid_full", 32'(a_out_data), 32'h3);
      a_in_valid = 4'b1111;
      reset      = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_data", 32'(a_out_data), 32'd0);
      chk("mid_rst_ch", 32'(a_out_ch), 32'd0);
      chk("mid_rst_rdy", 32'(a_in_ready), 32'd0);
      tick();
      chk("mid_rst_rdy_edge", 32'(a_in_ready), 32'd0);
      reset       = 1'b0;
      a_mode      = MODE_RR;
      a_out_ready = 1'b1;
      a_grant("post_rst_rr", 4'b0001, 4'b0011, 2'd0);
      a_in_valid = 4'b0000;
      tick();
      tick();

      // Three channels: out-of-range select never grants, round robin wraps at 3.
      b_in_data   = {4'b1101, 4'b1011, 4'b0111};
      b_mode      = MODE_FIXED;
      b_sel       = 2'd3;
      b_in_valid  = 3'b111;
      b_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("n3_sel3_rdy", 32'(b_in_ready), 32'd0);
         tick();
         chk("n3_sel3_valid", 32'(b_out_valid), 32'd0);
      end
      b_mode = MODE_RR;
      b_grant("n3_rr", 3'b001, 4'b0111, 2'd0);
      b_grant("n3_rr", 3'b010, 4'b1011, 2'd1);
      b_grant("n3_rr", 3'b100, 4'b1101, 2'd2);
      b_grant("n3_rr", 3'b001, 4'b0111, 2'd0);
      chk("n3_rr_ch_last", 32'(b_out_ch), 32'd0);
      b_in_valid = 3'b000;
      tick();
      chk("n3_drain", 32'(b_out_valid), 32'd0);
      tick();

      chk("qa_empty", 32'(qa.size()), 32'd0);
      chk("qb_empty", 32'(qb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
